// File: rtl/wb_fabric_decoder.sv
// Wishbone client aperture decoder with registered read mux and timeout termination.
// Optional WB_DEC_ERR_EN: timeouts end with WBs_ERR_o and capture the address in Err_Adr_o.
module wb_fabric_decoder #(
   parameter int NUM_CLIENTS = 4,
   parameter int APERWIDTH = 17,
   parameter int APERSIZE = 9,
   parameter logic [NUM_CLIENTS*(APERWIDTH-APERSIZE-2)-1:0] BASE_ADDRS = {6'd3, 6'd2, 6'd1, 6'd0},
   parameter logic [31:0] DEFAULT_READ_VALUE = 32'hBAD_FAB_AC,
   parameter int TIMEOUT_CNTR_WIDTH = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                      WBs_CLK_i,
   input  logic                      WBs_RST_n_i,
   input  logic [APERWIDTH-1:0]      WBs_ADR_i,
   input  logic                      WBs_CYC_i,
   input  logic                      WBs_STB_i,
   output logic [31:0]               WBs_RD_DAT_o,
   output logic                      WBs_ACK_o,
   output logic                      WBs_ERR_o,
   output logic [APERWIDTH-1:0]      Err_Adr_o,
   output logic [NUM_CLIENTS-1:0]    Client_CYC_o,
   input  logic [NUM_CLIENTS-1:0]    Client_ACK_i,
   input  logic [NUM_CLIENTS*32-1:0] Client_DAT_i
);
   localparam int DW = APERWIDTH - APERSIZE - 2;
   localparam int SW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t                        state, state_nxt;
   logic                          hit_q, hit_d;
   logic [SW-1:0]                 sel_q, sel_d;
   logic [TIMEOUT_CNTR_WIDTH-1:0] cnt;
   logic                          start, inc, done_ok, done_to, client_ack;
   logic [DW-1:0]                 field;

   assign field      = WBs_ADR_i[APERWIDTH-1:APERSIZE+2];
   assign client_ack = hit_q & Client_ACK_i[sel_q];

   // Scan from the top so the lowest matching index is the one left standing.
   always_comb begin
      hit_d = 1'b0;
      sel_d = '0;
      for (int i = NUM_CLIENTS-1; i >= 0; i--) begin
         if (field == BASE_ADDRS[i*DW +: DW]) begin
            hit_d = 1'b1;
            sel_d = SW'(i);
         end
      end
   end

   always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
      if (!WBs_RST_n_i) state <= IDLE;
      else              state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      start        = 1'b0;
      inc          = 1'b0;
      done_ok      = 1'b0;
      done_to      = 1'b0;
      Client_CYC_o = '0;
      case (state)
         IDLE: begin
            if (WBs_CYC_i & WBs_STB_i) begin
               start     = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            Client_CYC_o[sel_q] = hit_q & WBs_CYC_i;
            if (!WBs_CYC_i) begin
               state_nxt = IDLE;
            end else if (client_ack) begin
               done_ok   = 1'b1;
               state_nxt = DONE;
            end else if (cnt == TIMEOUT_CNTR_WIDTH'(TIMEOUT)) begin
               done_to   = 1'b1;
               state_nxt = DONE;
            end else begin
               inc = 1'b1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
      if (!WBs_RST_n_i) begin
         hit_q        <= 1'b0;
         sel_q        <= '0;
         cnt          <= '0;
         WBs_RD_DAT_o <= '0;
         WBs_ACK_o    <= 1'b0;
      end else begin
         if (start) begin
            hit_q <= hit_d;
            sel_q <= sel_d;
            cnt   <= '0;
         end else if (inc) begin
            cnt <= cnt + 1'b1;
         end
`ifdef WB_DEC_ERR_EN
         WBs_ACK_o <= done_ok;
         if (done_ok) WBs_RD_DAT_o <= Client_DAT_i[sel_q*32 +: 32];
`else
         WBs_ACK_o <= done_ok | done_to;
         if (done_ok)      WBs_RD_DAT_o <= Client_DAT_i[sel_q*32 +: 32];
         else if (done_to) WBs_RD_DAT_o <= DEFAULT_READ_VALUE;
`endif
      end
   end

`ifdef WB_DEC_ERR_EN
   logic [APERWIDTH-1:0] adr_q;

   always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
      if (!WBs_RST_n_i) begin
         adr_q     <= '0;
         Err_Adr_o <= '0;
         WBs_ERR_o <= 1'b0;
      end else begin
         if (start)   adr_q     <= WBs_ADR_i;
         if (done_to) Err_Adr_o <= adr_q;
         WBs_ERR_o <= done_to;
      end
   end
`else
   logic unused_adr;

   assign unused_adr = ^WBs_ADR_i[APERSIZE+1:0];
   assign WBs_ERR_o  = 1'b0;
   assign Err_Adr_o  = '0;
`endif

endmodule

// File: tb/tb_wb_fabric_decoder.sv
// Self-checking bench for wb_fabric_decoder: directed corner cases plus randomized reads
// checked against a transaction-level model (aperture lookup, ack delay vs. timeout).
module tb_wb_fabric_decoder;
   localparam logic [31:0] DEFV    = 32'hBADFABAC;
   localparam int          TIMEOUT = 15;
`ifdef WB_DEC_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif
   localparam logic [23:0] BASES1 = {6'd3, 6'd2, 6'd1, 6'd0};
   localparam logic [23:0] BASES2 = {6'd1, 6'd2, 6'd1, 6'd0};

   logic         clk = 1'b0, rst_n = 1'b0;
   logic [16:0]  adr = '0, adr2 = '0;
   logic         cyc = 1'b0, stb = 1'b0, cyc2 = 1'b0, stb2 = 1'b0;
   logic [3:0]   cack = '0, cack2 = '0;
   logic [127:0] cdat = '0, cdat2 = '0;
   logic [31:0]  rd, rd2;
   logic         ack, err, ack2, err2;
   logic [16:0]  eadr, eadr2;
   logic [3:0]   ccyc, ccyc2;

   int          checks = 0, failures = 0;
   logic [31:0] last_rd = '0;
   logic [16:0] exp_eadr = '0;

   always #5 clk = ~clk;

   wb_fabric_decoder dut (
      .WBs_CLK_i(clk), .WBs_RST_n_i(rst_n), .WBs_ADR_i(adr), .WBs_CYC_i(cyc), .WBs_STB_i(stb),
      .WBs_RD_DAT_o(rd), .WBs_ACK_o(ack), .WBs_ERR_o(err), .Err_Adr_o(eadr),
      .Client_CYC_o(ccyc), .Client_ACK_i(cack), .Client_DAT_i(cdat));

   wb_fabric_decoder #(.BASE_ADDRS(BASES2)) dut2 (
      .WBs_CLK_i(clk), .WBs_RST_n_i(rst_n), .WBs_ADR_i(adr2), .WBs_CYC_i(cyc2), .WBs_STB_i(stb2),
      .WBs_RD_DAT_o(rd2), .WBs_ACK_o(ack2), .WBs_ERR_o(err2), .Err_Adr_o(eadr2),
      .Client_CYC_o(ccyc2), .Client_ACK_i(cack2), .Client_DAT_i(cdat2));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Aperture lookup: decode field is byte address bits [16:11]; lowest index wins.
   function automatic int exp_sel(input logic [23:0] bases, input logic [16:0] a);
      int f;
      f = int'(a >> 11);
      for (int i = 0; i < 4; i++)
         if (int'(bases[i*6 +: 6]) == f) return i;
      return -1;
   endfunction

   // One read on dut; the selected client acks d cycles after its chip select rises.
   task automatic run_txn(input logic [16:0] a, input int d, input logic [31:0] data);
      int s, done;
      bit ok;
      logic [3:0] ecyc;
      s    = exp_sel(BASES1, a);
      ok   = (s >= 0) && (d <= TIMEOUT);
      done = ok ? d + 2 : TIMEOUT + 2;
      ecyc = (s >= 0) ? 4'(1 << s) : 4'b0000;
      adr = a; cyc = 1'b1; stb = 1'b1;
      cdat = {$urandom, $urandom, $urandom, $urandom};
      if (s >= 0) cdat[s*32 +: 32] = data;
      tick();
      for (int c = 1; c <= done; c++) begin
         chk("client_cyc", ccyc, (c < done) ? ecyc : 4'b0000);
         chk("ack", ack, (c == done) && (ok || !ERR_EN));
         chk("err", err, (c == done) && !ok && ERR_EN);
         if (c == done) begin
            if (ok)          last_rd = data;
            else if (!ERR_EN) last_rd = DEFV;
`ifdef WB_DEC_ERR_EN
            if (!ok) exp_eadr = a;
`endif
            chk("rd_data", rd, last_rd);
            chk("err_adr", eadr, exp_eadr);
         end
         cack = 4'($urandom) & ~ecyc;
         if (s >= 0 && c == d + 1) cack[s] = 1'b1;
         if (c == done) begin
            cyc = 1'b0; stb = 1'b0; cack = '0;
         end
         tick();
      end
      chk("idle_ack", ack, 1'b0);
      chk("rd_hold", rd, last_rd);
   endtask

   initial begin
      // reset state
      tick(); tick();
      chk("rst_rd", rd, 32'h0);
      chk("rst_ack", ack, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_eadr", eadr, 17'h0);
      chk("rst_cyc", ccyc, 4'h0);
      rst_n = 1'b1;
      tick();

      // directed cases
      run_txn(17'h00804, 3, 32'h12345678);
      run_txn(17'h1E000, 2, 32'h0);
      run_txn(17'h01000, 15, 32'hA5A5A5A5);
      run_txn(17'h01804, 16, 32'h5555AAAA);
      run_txn(17'h00000, 0, 32'hCAFEF00D);

      // CYC dropped in the third WAIT cycle
      adr = 17'h00804; cyc = 1'b1; stb = 1'b1;
      tick();
      chk("abort_cyc1", ccyc, 4'b0010);
      tick();
      chk("abort_cyc2", ccyc, 4'b0010);
      tick();
      chk("abort_cyc3", ccyc, 4'b0010);
      cyc = 1'b0; stb = 1'b0;
      #1;
      chk("abort_cyc_drop", ccyc, 4'b0000);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("abort_ack", ack, 1'b0);
         chk("abort_err", err, 1'b0);
         chk("abort_rd", rd, last_rd);
      end
      run_txn(17'h00A00, 1, 32'h0BADBEEF);

      // asynchronous reset in the middle of WAIT
      adr = 17'h01000; cyc = 1'b1; stb = 1'b1;
      tick(); tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rd", rd, 32'h0);
      chk("mid_rst_ack", ack, 1'b0);
      chk("mid_rst_cyc", ccyc, 4'h0);
      last_rd = '0; exp_eadr = '0;
      cyc = 1'b0; stb = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      run_txn(17'h00000, 0, 32'h600DF00D);

      // randomized reads
      for (int n = 0; n < 24; n++) begin
         logic [16:0] a;
         a = 17'($urandom);
         if ($urandom_range(0, 3) != 0) a[16:11] = 6'($urandom_range(0, 3));
         run_txn(a, $urandom_range(0, 20), $urandom);
      end

      // overlapping bases: clients 1 and 3 both decode field 1
      adr2 = 17'h00800; cyc2 = 1'b1; stb2 = 1'b1;
      cdat2[32 +: 32] = 32'h11111111;
      cdat2[96 +: 32] = 32'h33333333;
      tick();
      chk("ovl_cyc1", ccyc2, 4'(1 << exp_sel(BASES2, adr2)));
      cack2 = 4'b1000;
      tick();
      chk("ovl_cyc2", ccyc2, 4'b0010);
      chk("ovl_ack_ignored", ack2, 1'b0);
      cack2 = 4'b0010;
      tick();
      chk("ovl_ack", ack2, 1'b1);
      chk("ovl_rd", rd2, 32'h11111111);
      cyc2 = 1'b0; stb2 = 1'b0; cack2 = '0;
      tick();
      chk("ovl_idle_ack", ack2, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/wb_fabric_decoder.md
# wb_fabric_decoder

Parametrised Wishbone client decoder for the AL4S3B FPGA fabric, replacing the fixed two-aperture chip-select and read-mux logic in the FPGA IP top level. It decodes the AHB-to-FPGA bridge address into `NUM_CLIENTS` apertures and drives one chip-select per client. It returns a registered read-data/acknowledge to the bridge. A timeout state machine terminates accesses to unmapped apertures and accesses to non-responding clients, so the bridge never hangs.

## Interface
Parameters:
- `NUM_CLIENTS`, 4: number of client apertures, legal range 1..8.
- `APERWIDTH`, 17: bridge address width.
- `APERSIZE`, 9: word-address bits per aperture. The decode field is `WBs_ADR_i[APERWIDTH-1:APERSIZE+2]`, `DW = APERWIDTH-APERSIZE-2` bits wide.
- `BASE_ADDRS`, {6'd3,6'd2,6'd1,6'd0}: packed `NUM_CLIENTS*DW` vector of decode-field values; client i occupies slice i.
- `DEFAULT_READ_VALUE`, 32'hBAD_FAB_AC: read data returned on timeout.
- `TIMEOUT_CNTR_WIDTH`, 4: width of the timeout counter.
- `TIMEOUT`, 15: wait cycles before forced termination, 1..2^`TIMEOUT_CNTR_WIDTH`-1.

Ports:
- `WBs_CLK_i`, in, 1: fabric clock, single clock domain.
- `WBs_RST_n_i`, in, 1: asynchronous, active-low reset.
- `WBs_ADR_i`, in, `APERWIDTH`: bridge byte address.
- `WBs_CYC_i`, in, 1: bridge cycle.
- `WBs_STB_i`, in, 1: bridge strobe.
- `WBs_RD_DAT_o`, out, 32: registered read data to the bridge.
- `WBs_ACK_o`, out, 1: one-cycle acknowledge to the bridge.
- `WBs_ERR_o`, out, 1: one-cycle error termination; only driven when `WB_DEC_ERR_EN` is defined.
- `Err_Adr_o`, out, `APERWIDTH`: address of the last timed-out access; only driven when `WB_DEC_ERR_EN` is defined.
- `Client_CYC_o`, out, `NUM_CLIENTS`: per-client chip select, at most one bit set (one-hot or zero).
- `Client_ACK_i`, in, `NUM_CLIENTS`: per-client acknowledge.
- `Client_DAT_i`, in, `NUM_CLIENTS*32`: per-client read data; client i occupies slice i.

The address, write data, WE, RD and BYTE_STB signals are fanned out to the clients by the top level; they do not pass through this block.

## Operation
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- **IDLE:** when `WBs_CYC_i & WBs_STB_i` is high:
  - latch `hit` (any base matches) and `sel` (lowest matching index); overlapping bases resolve to the lowest index;
  - clear the counter to 0;
  - go to WAIT.
- **WAIT:**
  - `Client_CYC_o[sel] = hit & WBs_CYC_i`; all other bits are 0.
  - If `WBs_CYC_i` drops: abort to IDLE with no ACK/ERR, and leave `WBs_RD_DAT_o` unchanged.
  - Else if `hit & Client_ACK_i[sel]`: capture `Client_DAT_i[sel]` into `WBs_RD_DAT_o`, go to DONE (ok).
  - Else if counter == `TIMEOUT`: go to DONE (timeout); a client ACK in the same cycle wins over the timeout.
  - Else increment the counter.
- **DONE:** lasts one cycle.
  - On ok, `WBs_ACK_o` = 1.
  - On timeout without the macro, `WBs_ACK_o` = 1 and `WBs_RD_DAT_o = DEFAULT_READ_VALUE`.
  - `Client_CYC_o` = 0 in DONE.
  - Next state is always IDLE. A new request is accepted in IDLE only, so there is at least one idle cycle between accesses.
- ACK of a non-selected client is ignored in every state.
- Unmapped address (`hit` = 0): no chip select is driven; the access always times out.

## Timing
- Reset values: `WBs_RD_DAT_o` = 0, `WBs_ACK_o` = 0, `WBs_ERR_o` = 0, `Err_Adr_o` = 0, `Client_CYC_o` = 0, counter = 0. Reset applies asynchronously, including mid-access; the FSM returns to IDLE and no ACK is issued.
- Request sampled in cycle 0:
  - `Client_CYC_o` rises in cycle 1;
  - a client ACK in cycle k gives `WBs_ACK_o` and valid data in cycle k+1;
  - minimum latency is 2 cycles.
- Timeout: `WBs_ACK_o`/`WBs_ERR_o` in cycle `TIMEOUT`+2 after the request; default 17.
- `WBs_ACK_o`, `WBs_ERR_o` and `WBs_RD_DAT_o` are flop outputs. `Client_CYC_o` is decoded from registered state and `WBs_CYC_i`.
- `WBs_RD_DAT_o` holds its value until the next completion.

## Configuration
- `WB_DEC_ERR_EN` defined:
  - timeout terminates with `WBs_ERR_o` = 1 for one cycle instead of `WBs_ACK_o`;
  - `WBs_RD_DAT_o` is unchanged on timeout;
  - `Err_Adr_o` captures the `WBs_ADR_i` value latched in IDLE.
- `WB_DEC_ERR_EN` undefined:
  - `WBs_ERR_o` and `Err_Adr_o` are tied to 0;
  - timeout returns `DEFAULT_READ_VALUE` with `WBs_ACK_o`.

## Test plan
All scenarios use default parameters.
- Read at 0x00804, client 1 ACKs 3 cycles after its CYC with data 0x12345678 -> `Client_CYC_o` = 4'b0010 only; `WBs_ACK_o` for one cycle; `WBs_RD_DAT_o` = 0x12345678.
- Access to 0x1E000 (unmapped) -> `Client_CYC_o` stays 0. Without the macro: ACK in cycle 17 with 0xBADFABAC. With the macro: ERR in cycle 17 and `Err_Adr_o` = 0x1E000.
- Client 2 ACK arrives exactly in the cycle the counter equals 15, data 0xA5A5A5A5 -> normal ACK with 0xA5A5A5A5, no error.
- `WBs_CYC_i` dropped in cycle 3 of WAIT -> FSM returns to IDLE; no ACK/ERR; `WBs_RD_DAT_o` unchanged; the next access completes normally.
- `WBs_RST_n_i` asserted mid-WAIT -> all outputs 0 immediately; after release an access to 0x00000 with client 0 ACK completes in 2 cycles.
- `BASE_ADDRS` with clients 1 and 3 both set to 6'd1, access to 0x00800 -> only `Client_CYC_o[1]` is asserted; `Client_ACK_i[3]` is ignored.
